// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrated selector with valid/ready handshakes
// on every input and a single registered output slot.
//
// A combinational arbiter chooses at most one valid channel each cycle.
// The arbitration policy is fixed at elaboration time by MODE:
//   0 = round-robin, starting the search at a rotating pointer
//   1 = fixed priority, lowest index wins
//   2 = forced select, the channel named by force_sel
// The granted word loads into the output register whenever that register
// is empty or being drained in the same cycle. A full register that is
// being drained can therefore take a new word without a bubble.
// in_ready depends combinationally on out_ready, so a downstream stall
// reaches the producers in the same cycle.

module rr_arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    localparam int SELW  = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    force_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src
);

    // Round-robin search start. It only moves in MODE 0 and stays at zero otherwise.
    logic [SELW-1:0]  ptr;

    // Arbiter results: one-hot grant vector, its index, and a "someone won" flag.
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             grant_any;

    // The granted channel's word, taken from the packed input bus.
    logic [WIDTH-1:0] sel_data;

    // The output slot can accept a word this cycle.
    logic             load_en;

    // The slot is free when it is empty or when its word leaves on this edge.
    always_comb begin
        load_en = !out_valid || out_ready;
    end

    // Arbiter: pick at most one valid channel according to the elaborated policy.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (MODE == 0) begin
            // Scan N positions beginning at ptr, wrapping around the channel count.
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr) + k) % N;
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end else if (MODE == 1) begin
            // Fixed priority: the first valid channel from index 0 upward wins.
            for (int k = 0; k < N; k++) begin
                if (!found && in_valid[k]) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end else begin
            // Forced select. An out-of-range selector never grants anything.
            if (int'(force_sel) < N) begin
                if (in_valid[force_sel]) begin
                    grant[force_sel] = 1'b1;
                end
            end
        end
    end

    // Encode the one-hot grant into a channel index and flag any grant.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = SELW'(i);
            end
        end
        grant_any = |grant;
    end

    // AND-OR mux of the channel words. The grant is one-hot, so the result is exact.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    // Handshake back to the producers: only the granted channel, and only when the slot is free.
    always_comb begin
        in_ready = grant & {N{load_en}};
    end

    // Output slot: load on a transfer, empty when free and nothing is granted, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load_en) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Move the round-robin pointer to the channel after the winner, wrapping N-1 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if ((MODE == 0) && load_en && grant_any) begin
            if (grant_idx == SELW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux. The bench runs three instances side by side
// (round-robin, fixed priority and forced select), and all three share
// one set of input stimulus. Each instance is compared with a transaction-level
// model that holds the output slot contents and the round-robin start position.

module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic               clk;
    logic               rst;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [SELW-1:0]    force_sel;
    logic               out_ready;

    logic [N-1:0]       rdy [3];
    logic               ov  [3];
    logic [WIDTH-1:0]   od  [3];
    logic [SELW-1:0]    os  [3];

    int checks_total;
    int checks_passed;

    // Model state for each instance. Index = MODE.
    bit          m_valid [3];
    logic [31:0] m_data  [3];
    int          m_src   [3];
    int          m_start;

    rr_arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .force_sel(force_sel), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_src(os[0])
    );

    rr_arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .force_sel(force_sel), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_src(os[1])
    );

    rr_arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(2)) dut_fs (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(in_data), .force_sel(force_sel), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_src(os[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the values disagree.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Return the winning channel for a policy, or -1 if no channel wins.
    function automatic int pickWinner(int mode, logic [N-1:0] v, int start, int fsel);
        if (mode == 0) begin
            for (int k = 0; k < N; k++) begin
                if (v[(start + k) % N]) return (start + k) % N;
            end
        end else if (mode == 1) begin
            for (int c = 0; c < N; c++) begin
                if (v[c]) return c;
            end
        end else begin
            if (fsel < N && v[fsel]) return fsel;
        end
        return -1;
    endfunction

    task automatic resetModels();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_src[d]   = 0;
        end
        m_start = 0;
    endtask

    task automatic checkAllOutputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s_valid_m%0d", tag, d), 64'(ov[d]), 64'(m_valid[d]));
            if (m_valid[d]) begin
                checkOutput($sformatf("%s_data_m%0d", tag, d), 64'(od[d]), 64'(m_data[d]));
                checkOutput($sformatf("%s_src_m%0d", tag, d), 64'(os[d]), 64'(m_src[d]));
            end
        end
    endtask

    // One clock cycle. Call it at a falling edge. It drives the inputs, checks the
    // handshakes, advances the models on the rising edge, and checks the outputs
    // at the next falling edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d,
                                 input logic [SELW-1:0] fs, input logic ordy);
        int  win  [3];
        bit  load [3];
        logic [N-1:0] exp_rdy;
        in_valid  = v;
        in_data   = d;
        force_sel = fs;
        out_ready = ordy;
        #1;
        for (int m = 0; m < 3; m++) begin
            win[m]  = pickWinner(m, v, m_start, int'(fs));
            load[m] = !m_valid[m] || ordy;
            exp_rdy = '0;
            if (load[m] && win[m] >= 0) exp_rdy[win[m]] = 1'b1;
            checkOutput($sformatf("in_ready_m%0d", m), 64'(rdy[m]), 64'(exp_rdy));
        end
        @(posedge clk);
        for (int m = 0; m < 3; m++) begin
            if (load[m]) begin
                if (win[m] >= 0) begin
                    m_valid[m] = 1'b1;
                    m_data[m]  = d[win[m]*WIDTH +: WIDTH];
                    m_src[m]   = win[m];
                    if (m == 0) m_start = (win[m] + 1) % N;
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
        end
        @(negedge clk);
        checkAllOutputs("out");
    endtask

    function automatic logic [N*WIDTH-1:0] packWords(logic [31:0] w0, logic [31:0] w1,
                                                     logic [31:0] w2, logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    initial begin
        logic [N*WIDTH-1:0] seq_data;
        logic [N*WIDTH-1:0] rnd_data;
        checks_total  = 0;
        checks_passed = 0;
        in_valid  = '0;
        in_data   = '0;
        force_sel = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        resetModels();
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset_valid_m%0d", d), 64'(ov[d]), 64'd0);
            checkOutput($sformatf("reset_data_m%0d", d), 64'(od[d]), 64'd0);
            checkOutput($sformatf("reset_src_m%0d", d), 64'(os[d]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Load 0xDEADBEEF into the round-robin slot, then reset in the middle of a cycle.
        applyStimulus(4'b0001, packWords(32'hDEADBEEF, 0, 0, 0), 2'd0, 1'b1);
        checkOutput("pre_reset_data", 64'(od[0]), 64'hDEADBEEF);
        checkOutput("pre_reset_valid", 64'(ov[0]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_valid", 64'(ov[0]), 64'd0);
        checkOutput("async_reset_data", 64'(od[0]), 64'd0);
        checkOutput("async_reset_src", 64'(os[0]), 64'd0);
        resetModels();
        @(negedge clk);
        rst = 1'b0;

        // Round-robin rotation with every channel valid.
        seq_data = packWords(32'h1000, 32'h1001, 32'h1002, 32'h1003);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, seq_data, 2'd0, 1'b1);
            checkOutput($sformatf("rr_seq_data%0d", k), 64'(od[0]), 64'(32'h1000 + (k % 4)));
            checkOutput($sformatf("rr_seq_src%0d", k), 64'(os[0]), 64'(k % 4));
        end

        // Backpressure: channel 2 holds 0xA5A5A5A5 through a three-cycle stall.
        applyStimulus(4'b0100, packWords(0, 0, 32'hA5A5A5A5, 0), 2'd0, 1'b1);
        checkOutput("bp_loaded", 64'(od[0]), 64'hA5A5A5A5);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1111, seq_data, 2'd0, 1'b0);
            checkOutput($sformatf("bp_hold%0d", k), 64'(od[0]), 64'hA5A5A5A5);
        end
        applyStimulus(4'b1111, seq_data, 2'd0, 1'b1);
        checkOutput("bp_release_src", 64'(os[0]), 64'd3);
        checkOutput("bp_release_data", 64'(od[0]), 64'h1003);

        // Fixed priority: channel 1 beats channel 3 until channel 1 drops out.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1010, seq_data, 2'd0, 1'b1);
            checkOutput($sformatf("fp_ch1_%0d", k), 64'(os[1]), 64'd1);
        end
        applyStimulus(4'b1000, seq_data, 2'd0, 1'b1);
        checkOutput("fp_ch3", 64'(os[1]), 64'd3);

        // Forced select on channel 3. The slot empties once channel 3 goes idle.
        applyStimulus(4'b1111, seq_data, 2'd3, 1'b1);
        checkOutput("fs_src", 64'(os[2]), 64'd3);
        checkOutput("fs_valid", 64'(ov[2]), 64'd1);
        applyStimulus(4'b0111, seq_data, 2'd3, 1'b1);
        checkOutput("fs_drain", 64'(ov[2]), 64'd0);

        // Sparse round-robin: grant 1 (start moves to 2), then only 0 valid wraps, then 1 wins.
        applyStimulus(4'b0010, seq_data, 2'd0, 1'b1);
        checkOutput("sparse_a", 64'(os[0]), 64'd1);
        applyStimulus(4'b0001, seq_data, 2'd0, 1'b1);
        checkOutput("sparse_wrap", 64'(os[0]), 64'd0);
        applyStimulus(4'b0011, seq_data, 2'd0, 1'b1);
        checkOutput("sparse_next", 64'(os[0]), 64'd1);

        // Random traffic against the models.
        for (int k = 0; k < 400; k++) begin
            rnd_data = packWords($urandom, $urandom, $urandom, $urandom);
            applyStimulus(N'($urandom), rnd_data, SELW'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-input, WIDTH-bit selector with per-channel valid/ready handshake and a registered output stage.
- Generalises the datapath 2:1 and 4:1 select muxes to N channels, adds arbitration, flow control and one cycle of buffering.
- Used where several producers (e.g. writeback sources, memory-request sources) compete for one pipeline slot.

Parameters:
- WIDTH, 32: data width per channel.
- N, 4: number of input channels, N >= 2.
- MODE, 0: arbitration policy. 0 = round-robin, 1 = fixed priority (lowest index wins), 2 = forced select by force_sel.
- SELW: local, not overridable; = clog2(N), minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N  bit i = channel i presents data.
- in_ready  out  N  bit i = channel i's word is taken this cycle.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- force_sel  in  SELW  channel to pass; used only when MODE=2.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accepts the word this cycle.
- out_data  out  WIDTH  registered selected word.
- out_src  out  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0. Any held word is discarded.
- After reset is released, operation starts on the next rising edge.
- load_en = !out_valid || out_ready. The output register loads when load_en is high and a grant exists.
- There is a combinational path from out_ready to in_ready; this path is required.
- Grant is combinational, one-hot or zero, and only for a channel with in_valid=1.
  - MODE 0: search starts at ptr and wraps modulo N; the first valid channel is granted.
  - MODE 1: the lowest-indexed valid channel is granted.
  - MODE 2: channel force_sel is granted if it is valid. If force_sel >= N, there is no grant.
- in_ready[i] = load_en && grant[i]. At most one in_ready bit is high per cycle, and in_ready never asserts without a matching in_valid.
- On a transfer (load_en && grant to g), at the clock edge:
  - out_data <= in_data[g]
  - out_src <= g
  - out_valid <= 1
  - MODE 0 only: ptr <= (g+1) mod N, so ptr wraps from N-1 to 0.
- If load_en=1 and there is no grant, out_valid <= 0 on the clock edge. out_data and out_src hold their values.
- ptr changes only on a grant in MODE 0. It is unused in MODES 1 and 2.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_data and out_src stay stable and all in_ready bits are 0.
- Simultaneous drain and refill (out_valid=1, out_ready=1, grant present): the old word leaves and the new word loads on the same edge, with no bubble.
- A channel that drops in_valid without a handshake is simply not granted. No state is kept per channel.
- Fairness, MODE 0: with all channels continuously valid and out_ready=1, grants rotate 0,1,...,N-1,0,... and each channel is served once per N cycles.

Test Plan:
- Reset: rst pulsed mid-stream while out_valid=1 and out_data=0xDEADBEEF -> out_valid, out_data and out_src read 0 immediately (asynchronously); first grant after release goes to channel 0 in MODE 0.
- Round-robin, N=4, MODE 0: all in_valid=1, in_data[i]=0x1000+i, out_ready=1 -> out_data sequence 0x1000,0x1001,0x1002,0x1003,0x1000; out_src sequence 0,1,2,3,0; exactly one in_ready bit per cycle.
- Backpressure: out_ready=0 for 3 cycles while channel 2 holds 0xA5A5A5A5 -> out_data stays 0xA5A5A5A5 and all in_ready=0 for those 3 cycles; when out_ready=1, the next word loads on that same edge.
- Fixed priority, MODE 1: in_valid=4'b1010 -> channel 1 granted every cycle; channel 3 is granted only once in_valid=4'b1000.
- Forced, MODE 2: force_sel=3, in_valid=4'b1111 -> only in_ready[3] asserts and out_src=3. With force_sel=3 and in_valid[3]=0, out_valid falls to 0 after the current word drains.
- Sparse, MODE 0: ptr=2 and only channel 0 valid -> the search wraps and grants 0, then ptr=1; next, channels 0 and 1 both valid -> channel 1 granted.
